// File: rtl/mips32_data_mem_responder.sv
// Multi-cycle data-memory responder: latches one load/store, waits WAIT_STATES cycles,
// then answers with a one-cycle ready strobe, flagging misaligned/out-of-range/ambiguous requests.
module mips32_data_mem_responder #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
);

   localparam int         DEPTH = 1 << ADDR_WIDTH;
   localparam logic [3:0] WS    = 4'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                  state, state_nx;
   logic [3:0]              wait_cnt, wait_cnt_nx;
   logic                    rd_q, wr_q;
   logic [31:0]             addr_q, wdata_q;
   logic [31:0]             mem [DEPTH];
   logic [ADDR_WIDTH-1:0]   idx;
   logic                    accept, acc_err, load_ok, store_ok;

   assign accept   = (state == S_IDLE) && (mem_read || mem_write);
   assign idx      = addr_q[ADDR_WIDTH+1:2];
   assign acc_err  = (addr_q[1:0] != 2'b00)
                   || ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0)
                   || (rd_q && wr_q);
   assign load_ok  = (state == S_RESP) && rd_q && !acc_err;
   assign store_ok = (state == S_RESP) && wr_q && !acc_err;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nx    = state;
      wait_cnt_nx = wait_cnt;
      case (state)
         S_IDLE: if (accept) begin
            if (WS == 4'd0) state_nx = S_RESP;
            else begin
               state_nx    = S_WAIT;
               wait_cnt_nx = WS - 4'd1;
            end
         end
         S_WAIT: if (wait_cnt == 4'd0) state_nx = S_RESP;
                 else wait_cnt_nx = wait_cnt - 4'd1;
         S_RESP:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         wait_cnt <= 4'd0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         rd_count <= 16'd0;
         wr_count <= 16'd0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_cnt_nx;
         if (accept) begin
            rd_q <= mem_read;
            wr_q <= mem_write;
         end
         if (load_ok && rd_count != 16'hFFFF)  rd_count <= rd_count + 16'd1;
         if (store_ok && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end
   end

   // NOTE: the storage array and data latches carry no reset; only control state is reset,
   // and a store is suppressed when reset lands on its commit edge.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= addr;
         wdata_q <= wdata;
      end
      if (store_ok && rst_n) mem[idx] <= wdata_q;
   end

   assign ready = (state == S_RESP);
   assign busy  = (state != S_IDLE);
   assign err   = ready && acc_err;
   assign rdata = load_ok ? mem[idx] : 32'd0;

endmodule

// File: tb/tb_mips32_data_mem_responder.sv
// Self-checking bench: directed vector table plus hand sequences for latching,
// reset abort, back-to-back throughput and counter saturation.
module tb_mips32_data_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst_n, mem_read, mem_write;
   logic [31:0] addr, wdata, rdata;
   logic        ready, err, busy;
   logic [15:0] rd_count, wr_count;

   logic        z_read, z_write;
   logic [31:0] z_addr, z_wdata, z_rdata;
   logic        z_ready, z_err, z_busy;
   logic [15:0] z_rd_count, z_wr_count;

   mips32_data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
      .busy(busy), .rd_count(rd_count), .wr_count(wr_count)
   );

   mips32_data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .mem_read(z_read), .mem_write(z_write),
      .addr(z_addr), .wdata(z_wdata), .rdata(z_rdata), .ready(z_ready), .err(z_err),
      .busy(z_busy), .rd_count(z_rd_count), .wr_count(z_wr_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   typedef struct {
      logic        rd, wr;
      logic [31:0] a, d, exp_r;
      logic        exp_e;
      logic [15:0] exp_rc, exp_wc;
   } vec_t;

   vec_t vecs[12];

   // Waits up to 20 cycles for ready on the WAIT_STATES=2 instance.
   task automatic wait_ready(output logic [31:0] r, output logic e, output int lat,
                             output logic leak);
      lat = 0; leak = 1'b0; r = 32'd0; e = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (ready) begin
            lat = i; r = rdata; e = err;
            break;
         end
         if (rdata != 32'd0 || err) leak = 1'b1;
      end
   endtask

   task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] r, output logic e,
                          output int lat, output logic leak);
      @(negedge clk);
      mem_read = rd; mem_write = wr; addr = a; wdata = d;
      @(posedge clk);
      #1;
      mem_read = 1'b0; mem_write = 1'b0; addr = $urandom; wdata = $urandom;
      wait_ready(r, e, lat, leak);
      @(negedge clk);
   endtask

   logic [31:0] r;
   logic        e, leak, seen;
   int          lat, nr;
   int          t[4];

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'h0,        1'b0, 16'd0, 16'd1};
      vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0, 16'd1, 16'd1};
      vecs[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,        32'h0,        1'b1, 16'd1, 16'd1};
      vecs[3]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hA5A5A5A5, 32'h0,        1'b0, 16'd1, 16'd2};
      vecs[4]  = '{1'b0, 1'b1, 32'h0000_0400, 32'hFFFF0000, 32'h0,        1'b1, 16'd1, 16'd2};
      vecs[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        32'hA5A5A5A5, 1'b0, 16'd2, 16'd2};
      vecs[6]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h11111111, 32'h0,        1'b1, 16'd2, 16'd2};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0, 16'd3, 16'd2};
      vecs[8]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,        32'h0,        1'b1, 16'd3, 16'd2};
      vecs[9]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hCAFEF00D, 32'h0,        1'b0, 16'd3, 16'd3};
      vecs[10] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,        32'hCAFEF00D, 1'b0, 16'd4, 16'd3};
      vecs[11] = '{1'b0, 1'b1, 32'h0000_0004, 32'h0BADC0DE, 32'h0,        1'b0, 16'd4, 16'd4};

      rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = 32'd0; wdata = 32'd0;
      z_read = 1'b0; z_write = 1'b0; z_addr = 32'd0; z_wdata = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("reset_outputs", {15'd0, ready, busy, err, rd_count}, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      check("reset_wr_count", {16'd0, wr_count}, 32'd0);

      // Directed vector table
      for (int i = 0; i < 12; i++) begin
         run_txn(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, r, e, lat, leak);
         check($sformatf("v%0d_rdata", i), r, vecs[i].exp_r);
         check($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_e});
         check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
         check($sformatf("v%0d_quiet_when_not_ready", i), {31'd0, leak}, 32'd0);
         check($sformatf("v%0d_rd_count", i), {16'd0, rd_count}, {16'd0, vecs[i].exp_rc});
         check($sformatf("v%0d_wr_count", i), {16'd0, wr_count}, {16'd0, vecs[i].exp_wc});
      end

      // Inputs changed after acceptance: response must use the latched load
      @(negedge clk);
      mem_read = 1'b1; addr = 32'h10;
      @(posedge clk);
      #1;
      mem_read = 1'b0; mem_write = 1'b1; addr = 32'h0; wdata = 32'h77777777;
      @(negedge clk);
      check("latched_busy", {31'd0, busy}, 32'd1);
      mem_write = 1'b0;
      wait_ready(r, e, lat, leak);
      check("latched_rdata", r, 32'hDEADBEEF);
      check("latched_err", {31'd0, e}, 32'd0);
      @(negedge clk);
      check("latched_rd_count", {16'd0, rd_count}, 32'd5);
      check("latched_wr_count", {16'd0, wr_count}, 32'd4);
      run_txn(1'b1, 1'b0, 32'h0, 32'h0, r, e, lat, leak);
      check("latched_mem0_untouched", r, 32'hA5A5A5A5);

      // Reset one cycle after accepting a store aborts it
      @(negedge clk);
      mem_write = 1'b1; addr = 32'h4; wdata = 32'h12345678;
      @(posedge clk);
      #1;
      mem_write = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_outputs", {12'd0, ready, busy, err, 1'b0, rd_count}, 32'd0);
      check("abort_rdata_wr_count", rdata | {16'd0, wr_count}, 32'd0);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (ready) seen = 1'b1;
      end
      check("abort_no_ready", {31'd0, seen}, 32'd0);
      run_txn(1'b1, 1'b0, 32'h4, 32'h0, r, e, lat, leak);
      check("abort_mem1_old_value", r, 32'h0BADC0DE);
      check("abort_rd_count", {16'd0, rd_count}, 32'd1);
      check("abort_wr_count", {16'd0, wr_count}, 32'd0);

      // Back-to-back loads, WAIT_STATES=2: one ready every 4 cycles
      @(negedge clk);
      mem_read = 1'b1; addr = 32'h10;
      nr = 0;
      for (int i = 0; i < 40 && nr < 4; i++) begin
         @(negedge clk);
         if (ready) begin
            t[nr] = cyc; nr++;
            if (nr == 4) mem_read = 1'b0;
         end
      end
      mem_read = 1'b0;
      check("b2b_ws2_count", 32'(nr), 32'd4);
      for (int i = 1; i < 4; i++) check($sformatf("b2b_ws2_gap%0d", i), 32'(t[i] - t[i-1]), 32'd4);
      repeat (4) @(negedge clk);
      check("b2b_ws2_rd_count", {16'd0, rd_count}, 32'd5);

      // Back-to-back loads, WAIT_STATES=0: one ready every 2 cycles
      @(negedge clk);
      z_read = 1'b1; z_addr = 32'h10;
      nr = 0;
      for (int i = 0; i < 40 && nr < 4; i++) begin
         @(negedge clk);
         if (z_ready) begin
            t[nr] = cyc; nr++;
            if (nr == 4) z_read = 1'b0;
         end
      end
      z_read = 1'b0;
      check("b2b_ws0_count", 32'(nr), 32'd4);
      for (int i = 1; i < 4; i++) check($sformatf("b2b_ws0_gap%0d", i), 32'(t[i] - t[i-1]), 32'd2);

      // Saturation of the load counter
      @(negedge clk);
      force dut.rd_count = 16'hFFFF;
      @(negedge clk);
      release dut.rd_count;
      run_txn(1'b1, 1'b0, 32'h10, 32'h0, r, e, lat, leak);
      check("sat_rdata", r, 32'hDEADBEEF);
      check("sat_rd_count", {16'd0, rd_count}, 32'h0000FFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, limit 200000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mips32_data_mem_responder.md
Name: mips32_data_mem_responder

Overview:
- Multi-cycle data-memory responder: the memory-side end of the core's data-memory interface (mem_read/mem_write, address, store data).
- Accepts one load or store per transaction, inserts WAIT_STATES wait cycles, then returns read data with a one-cycle ready pulse.
- Flags misaligned and out-of-range accesses.
- Sits between the core's data-memory port and a word-addressed storage array; it replaces the zero-latency memory model for multi-cycle and stall-capable cores.

Parameters:
- ADDR_WIDTH, 8, number of word-index bits; storage depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 2, wait cycles between acceptance and response (0..15).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- mem_read  input  1  load request.
- mem_write  input  1  store request.
- addr  input  32  byte address.
- wdata  input  32  store data.
- rdata  output  32  load data, valid only while ready=1.
- ready  output  1  one-cycle response strobe.
- err  output  1  error qualifier, valid only while ready=1.
- busy  output  1  high from the cycle after acceptance until the response cycle, inclusive.
- rd_count  output  16  completed loads, saturating.
- wr_count  output  16  completed stores, saturating.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - FSM goes to IDLE.
  - rdata=0, ready=0, err=0, busy=0, rd_count=0, wr_count=0.
  - Storage array contents are NOT cleared.
  - Reset during WAIT or RESP aborts the transaction: a pending store is discarded, no ready is issued and no counter changes.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read or mem_write is high, latch addr, wdata and the request type.
  - Go to WAIT with wait_cnt=WAIT_STATES-1, or go directly to RESP if WAIT_STATES=0.
  - Otherwise stay in IDLE.
- WAIT: wait_cnt decrements each cycle; when wait_cnt=0, go to RESP.
- RESP: ready=1 for exactly one cycle, then return to IDLE.
- Latency: acceptance edge to ready is WAIT_STATES+1 cycles. ready is registered.
- Inputs are ignored outside IDLE. All actions use the latched copies, so the initiator may change inputs after acceptance.
- Initiator rule: deassert the request in the cycle after ready. A request still high in IDLE is treated as a new transaction. Back-to-back throughput is one transaction per WAIT_STATES+2 cycles.
- Error conditions, all checked on latched values:
  - latched addr[1:0]≠0 (misaligned);
  - latched addr[31:ADDR_WIDTH+2]≠0 (out of range);
  - mem_read and mem_write both high at acceptance.
- On error, RESP asserts err=1 and rdata=0. No storage write occurs and no counter increments.
- Load (no error): rdata = mem[addr[ADDR_WIDTH+1:2]] during the RESP cycle; rd_count increments by 1.
- Store (no error): mem[index] <= wdata at the end of the RESP cycle; rdata=0; wr_count increments by 1. A load accepted immediately afterwards returns the new value.
- Counters saturate at 16'hFFFF and do not wrap.
- rdata and err are 0 in every cycle in which ready=0.

Test Plan:
- WAIT_STATES=2: store wdata=32'hDEADBEEF to addr=32'h0000_0010, then load addr=32'h10 → store ready 3 cycles after acceptance with err=0; load rdata=32'hDEADBEEF, err=0; wr_count=1, rd_count=1.
- Misaligned load addr=32'h0000_0013 → ready after 3 cycles with err=1, rdata=0; rd_count unchanged.
- Out-of-range store addr=32'h0000_0400 (ADDR_WIDTH=8) → err=1; a subsequent load from addr=32'h0 returns the prior contents unchanged.
- Both mem_read and mem_write high → err=1 and no counter change. Separately, change addr/wdata during WAIT → the response uses the latched values.
- Store 32'h1234_5678 to addr=32'h4, then assert rst_n=0 one cycle after acceptance → no ready issued, mem[1] unchanged, all outputs 0. A load from 32'h4 after reset returns the old value.
- Back-to-back: hold mem_read high → a ready every 4 cycles.
- WAIT_STATES=0 → ready every 2 cycles.
- Force rd_count to 16'hFFFF, then perform one more load → rd_count stays 16'hFFFF.
